dose_alert_sequencer: RTL and testbench
=======================================

# dose_alert_sequencer

Sequences the user-facing alert for medication doses flagged by the scheduler. Due events (`due_valid`, `due_idx`, `due_time`) go into a small pending FIFO. The block presents one dose at a time on the buzzer and LED, and resolves each dose as TAKEN (ack), SNOOZED (re-alert later) or MISSED (timeout). Each resolution is emitted as a record on a valid/ready log-write port feeding the dose logger, so the logger receives only outcomes, never raw due pulses.

## Interface
- `DEPTH`, 4, pending FIFO entries; power of two, at least 2.
- `ALERT_TICKS`, 16, ticks an alert lasts before the dose is MISSED; at least 1.
- `SNOOZE_TICKS`, 32, ticks of silence per snooze; at least 1.
- `MAX_SNOOZE`, 2, snoozes allowed per dose; 0 disables snooze.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `tick`  in  1  one-cycle timebase pulse; all timers and beep toggling advance only on `tick`.
- `due_valid`  in  1  one-cycle pulse: a dose is due.
- `due_idx`  in  4  medication index of the due dose.
- `due_time`  in  8  scheduler time stamp of the due dose.
- `ack_btn`  in  1  raw, asynchronous "taken" button.
- `snooze_btn`  in  1  raw, asynchronous snooze button.
- `log_valid`  out  1  log record available.
- `log_ready`  in  1  logger accepts the record.
- `log_data`  out  14  record = {time[7:0], idx[3:0], status[1:0]}; status 00 = TAKEN, 01 = MISSED.
- `buzzer`  out  1  beep output.
- `alert_led`  out  1  alert indicator.
- `active_idx`  out  4  index of the dose being presented; 0 in IDLE.
- `pending_cnt`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `overflow`  out  1  sticky; a due event was dropped.

## Operation
- FIFO:
  - Push on `due_valid` if `pending_cnt != DEPTH` at the start of the cycle.
  - When full, the event is dropped and `overflow` is set, even if a pop occurs in the same cycle.
  - Read/write pointers wrap modulo DEPTH.
  - `overflow` clears only on reset.
- Buttons:
  - Each button passes through a 2-flop synchronizer, then a rising-edge detector.
  - The resulting pulse (`ack_p`, `snooze_p`) is valid for one cycle.
  - A held button produces exactly one pulse.
- FSM states: IDLE, ALERT, SNOOZE, LOG.
- IDLE:
  - If the FIFO is non-empty, pop the head into active {time, idx}.
  - Then clear `timer`, `snooze_cnt` and `beep`, and go to ALERT.
- ALERT:
  - Outputs: `alert_led` = 1, `buzzer` = `beep`; `beep` toggles on each tick.
  - Priority within a cycle: `ack_p` > timeout > `snooze_p`.
  - `ack_p`: status TAKEN, go to LOG.
  - Timeout (tick while `timer` == ALERT_TICKS-1): status MISSED, go to LOG.
  - `snooze_p` with `snooze_cnt < MAX_SNOOZE`: increment `snooze_cnt`, clear `timer` and `beep`, go to SNOOZE.
  - `snooze_p` at the snooze limit is ignored.
  - Otherwise `timer` increments on tick.
- SNOOZE:
  - Outputs: `buzzer` = 0, `alert_led` = 0.
  - `ack_p`: status TAKEN, go to LOG.
  - Tick while `timer` == SNOOZE_TICKS-1: clear `timer` and `beep`, go to ALERT.
  - `snooze_p` is ignored.
- LOG:
  - `log_valid` = 1; `log_data` holds {active time, active idx, status}, stable until accepted.
  - On `log_valid && log_ready`, go to IDLE.
  - `buzzer` and `alert_led` are 0; buttons are ignored.
- Pushes are accepted in every state, including during pops.

## Timing
- Reset values (all outputs and state):
  - `log_valid`, `log_data`, `buzzer`, `alert_led`, `active_idx`, `pending_cnt` and `overflow` = 0.
  - FSM = IDLE; FIFO empty; timers 0.
- Reset mid-operation: the active dose and all pending entries are discarded and no record is emitted.
- `pending_cnt` updates on the edge that samples the push or pop.
- Empty FIFO in IDLE, `due_valid` sampled at edge N: pop at edge N+1, so ALERT and `active_idx` are visible after N+1.
- A button pin rising before edge N gives a pulse visible after edge N+2. The resulting state change occurs at edge N+3.
- Record throughput: LOG → IDLE on the accepting edge, then IDLE → ALERT on the next edge. This is one idle cycle between doses.
- `log_ready` held high: `log_valid` is high for exactly one cycle.
- With `tick` tied high, a MISSED dose sees ALERT_TICKS cycles in ALERT.

## Test plan
- Missed dose, defaults: tick = 1, `due_valid` with idx 3, time 0x2A, no buttons, `log_ready` = 1 → ALERT for 16 cycles, `buzzer` toggling each cycle, then `log_data` = {0x2A, 3, 01} for one cycle, then IDLE.
- Taken dose: `ack_btn` raised 5 cycles into ALERT → LOG 3 cycles later, status 00. `buzzer` and `alert_led` drop on entry to LOG.
- Snooze limit:
  - Press snooze 3 times, each in a separate ALERT.
  - Expect 2 SNOOZE periods of 32 cycles.
  - The third press is ignored; the dose then times out as MISSED.
- Backlog and overflow:
  - With one dose active, issue 5 `due_valid` pulses.
  - Expect `pending_cnt` = 4 and `overflow` = 1.
  - Acking each dose yields records for the first 5 events in order.
- Log backpressure: hold `log_ready` = 0 for 10 cycles → `log_valid` and `log_data` stay stable and the next dose is not popped. Release → accept, then ALERT two edges later.
- Simultaneous ack and timeout on the final tick → TAKEN. Asserting `rst_n` low in SNOOZE → all outputs 0 immediately and `pending_cnt` = 0.

Source files
------------

// File: rtl/dose_alert_sequencer.sv
// Dose alert sequencer: queues due doses, presents one at a time on buzzer/LED,
// and emits one TAKEN/MISSED outcome record per dose to the logger.
//
// state    | meaning
// S_IDLE   | no dose presented; pops the FIFO head when one is pending
// S_ALERT  | buzzer beeping, LED on, waiting for ack / snooze / timeout
// S_SNOOZE | silent wait before re-alerting; ack still accepted
// S_LOG    | outcome record held on the log port until accepted
module dose_alert_sequencer #(
    parameter int DEPTH        = 4,
    parameter int ALERT_TICKS  = 16,
    parameter int SNOOZE_TICKS = 32,
    parameter int MAX_SNOOZE   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     tick,
    input  logic                     due_valid,
    input  logic [3:0]               due_idx,
    input  logic [7:0]               due_time,
    input  logic                     ack_btn,
    input  logic                     snooze_btn,
    output logic                     log_valid,
    input  logic                     log_ready,
    output logic [13:0]              log_data,
    output logic                     buzzer,
    output logic                     alert_led,
    output logic [3:0]               active_idx,
    output logic [$clog2(DEPTH):0]   pending_cnt,
    output logic                     overflow
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int TMAX = (ALERT_TICKS > SNOOZE_TICKS) ? ALERT_TICKS : SNOOZE_TICKS;
    localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);
    localparam int SW   = (MAX_SNOOZE < 1) ? 1 : $clog2(MAX_SNOOZE + 1);

    localparam logic [TW-1:0] ALERT_LOAD   = TW'(ALERT_TICKS - 1);
    localparam logic [TW-1:0] SNOOZE_LOAD  = TW'(SNOOZE_TICKS - 1);
    localparam logic [SW-1:0] SNOOZE_LIMIT = SW'(MAX_SNOOZE);
    localparam logic [CW-1:0] FULL_CNT     = CW'(DEPTH);

    localparam logic [1:0] ST_TAKEN  = 2'b00;
    localparam logic [1:0] ST_MISSED = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ALERT,
        S_SNOOZE,
        S_LOG
    } state_t;

    state_t state_q, state_d;

    // Button conditioning: 2-flop synchronizer, then a registered rising-edge pulse
    logic [1:0] ack_sync, snz_sync;
    logic       ack_prev, snz_prev;
    logic       ack_p, snooze_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_sync <= '0;
            snz_sync <= '0;
            ack_prev <= 1'b0;
            snz_prev <= 1'b0;
            ack_p    <= 1'b0;
            snooze_p <= 1'b0;
        end else begin
            ack_sync <= {ack_sync[0], ack_btn};
            snz_sync <= {snz_sync[0], snooze_btn};
            ack_prev <= ack_sync[1];
            snz_prev <= snz_sync[1];
            ack_p    <= ack_sync[1] & ~ack_prev;
            snooze_p <= snz_sync[1] & ~snz_prev;
        end
    end

    // Pending FIFO of {time, idx}
    logic [11:0]   fifo_mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count_q;
    logic          fifo_full, fifo_empty, push, pop;

    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign push       = due_valid & ~fifo_full;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {due_time, due_idx};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (due_valid && fifo_full) begin
                overflow <= 1'b1;
            end
        end
    end

    assign pending_cnt = count_q;

    // Active dose datapath
    logic [7:0]    act_time;
    logic [3:0]    act_idx;
    logic [1:0]    status_q;
    logic [TW-1:0] timer_q;
    logic [SW-1:0] snooze_cnt_q;
    logic          beep_q;

    logic load_alert, enter_snooze, res_taken, res_missed, count_tick, beep_tgl;
    logic timer_tc;

    // Down-counter reaching zero on a tick marks the end of the current period
    assign timer_tc = tick && (timer_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        load_alert   = 1'b0;
        enter_snooze = 1'b0;
        res_taken    = 1'b0;
        res_missed   = 1'b0;
        count_tick   = 1'b0;
        beep_tgl     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    load_alert = 1'b1;
                    state_d    = S_ALERT;
                end
            end
            S_ALERT: begin
                if (ack_p) begin
                    res_taken = 1'b1;
                    state_d   = S_LOG;
                end else if (timer_tc) begin
                    res_missed = 1'b1;
                    state_d    = S_LOG;
                end else if (snooze_p && (snooze_cnt_q < SNOOZE_LIMIT)) begin
                    enter_snooze = 1'b1;
                    state_d      = S_SNOOZE;
                end else if (tick) begin
                    count_tick = 1'b1;
                    beep_tgl   = 1'b1;
                end
            end
            S_SNOOZE: begin
                if (ack_p) begin
                    res_taken = 1'b1;
                    state_d   = S_LOG;
                end else if (timer_tc) begin
                    load_alert = 1'b1;
                    state_d    = S_ALERT;
                end else if (tick) begin
                    count_tick = 1'b1;
                end
            end
            S_LOG: begin
                if (log_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_time     <= '0;
            act_idx      <= '0;
            status_q     <= ST_TAKEN;
            timer_q      <= '0;
            snooze_cnt_q <= '0;
            beep_q       <= 1'b0;
        end else begin
            if (pop) begin
                {act_time, act_idx} <= fifo_mem[rd_ptr];
                snooze_cnt_q        <= '0;
            end
            if (load_alert) begin
                timer_q <= ALERT_LOAD;
                beep_q  <= 1'b0;
            end
            if (enter_snooze) begin
                snooze_cnt_q <= snooze_cnt_q + SW'(1);
                timer_q      <= SNOOZE_LOAD;
                beep_q       <= 1'b0;
            end
            if (count_tick) begin
                timer_q <= timer_q - TW'(1);
            end
            if (beep_tgl) begin
                beep_q <= ~beep_q;
            end
            if (res_taken) begin
                status_q <= ST_TAKEN;
            end
            if (res_missed) begin
                status_q <= ST_MISSED;
            end
        end
    end

    always_comb begin
        log_valid  = 1'b0;
        log_data   = '0;
        buzzer     = 1'b0;
        alert_led  = 1'b0;
        active_idx = '0;
        case (state_q)
            S_ALERT: begin
                alert_led  = 1'b1;
                buzzer     = beep_q;
                active_idx = act_idx;
            end
            S_SNOOZE: begin
                active_idx = act_idx;
            end
            S_LOG: begin
                log_valid  = 1'b1;
                log_data   = {act_time, act_idx, status_q};
                active_idx = act_idx;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dose_alert_sequencer.sv
// Directed bench for dose_alert_sequencer: a per-cycle vector table for the
// missed-dose trace, plus hand-written sequences for the multi-cycle cases.
module tb_dose_alert_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        due_valid = 1'b0;
    logic [3:0]  due_idx = '0;
    logic [7:0]  due_time = '0;
    logic        ack_btn = 1'b0;
    logic        snooze_btn = 1'b0;
    logic        log_ready = 1'b1;
    logic        log_valid;
    logic [13:0] log_data;
    logic        buzzer;
    logic        alert_led;
    logic [3:0]  active_idx;
    logic [2:0]  pending_cnt;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    dose_alert_sequencer #(
        .DEPTH(4), .ALERT_TICKS(16), .SNOOZE_TICKS(32), .MAX_SNOOZE(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick),
        .due_valid(due_valid), .due_idx(due_idx), .due_time(due_time),
        .ack_btn(ack_btn), .snooze_btn(snooze_btn),
        .log_valid(log_valid), .log_ready(log_ready), .log_data(log_data),
        .buzzer(buzzer), .alert_led(alert_led), .active_idx(active_idx),
        .pending_cnt(pending_cnt), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        tick;
        logic        due_valid;
        logic [3:0]  idx;
        logic [7:0]  tm;
        logic        log_ready;
        logic        exp_lv;
        logic [13:0] exp_ld;
        logic        exp_buz;
        logic        exp_led;
        logic [3:0]  exp_aidx;
        logic [2:0]  exp_pend;
    } vec_t;

    vec_t vecs [19];

    function automatic logic [13:0] rec(input logic [7:0] t, input logic [3:0] i,
                                        input logic [1:0] s);
        return {t, i, s};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] i, input logic [7:0] t);
        due_valid = 1'b1;
        due_idx   = i;
        due_time  = t;
        step;
        due_valid = 1'b0;
    endtask

    task automatic wait_alert(input int max);
        int n = 0;
        while (alert_led !== 1'b1 && n < max) begin
            step;
            n++;
        end
        check("wait_alert", 32'(alert_led), 32'd1);
    endtask

    task automatic wait_log(input int max);
        int n = 0;
        while (log_valid !== 1'b1 && n < max) begin
            step;
            n++;
        end
        check("wait_log", 32'(log_valid), 32'd1);
    endtask

    task automatic press_ack;
        ack_btn = 1'b1;
        step;
        ack_btn = 1'b0;
    endtask

    initial begin
        int n;

        // Missed dose with tick tied high: 16 ALERT cycles, one LOG cycle, back to IDLE
        for (int i = 0; i < 19; i++) begin
            vecs[i]           = '0;
            vecs[i].tick      = 1'b1;
            vecs[i].log_ready = 1'b1;
        end
        vecs[0].due_valid = 1'b1;
        vecs[0].idx       = 4'd3;
        vecs[0].tm        = 8'h2A;
        vecs[0].exp_pend  = 3'd1;
        for (int k = 0; k < 16; k++) begin
            vecs[1+k].exp_led  = 1'b1;
            vecs[1+k].exp_aidx = 4'd3;
            vecs[1+k].exp_buz  = ((k % 2) != 0);
        end
        vecs[17].exp_lv   = 1'b1;
        vecs[17].exp_ld   = 14'h0A8D;
        vecs[17].exp_aidx = 4'd3;

        #12;
        check("rst_log_valid", 32'(log_valid), 32'd0);
        check("rst_log_data", 32'(log_data), 32'd0);
        check("rst_buzzer", 32'(buzzer), 32'd0);
        check("rst_led", 32'(alert_led), 32'd0);
        check("rst_active_idx", 32'(active_idx), 32'd0);
        check("rst_pending", 32'(pending_cnt), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            tick      = vecs[i].tick;
            due_valid = vecs[i].due_valid;
            due_idx   = vecs[i].idx;
            due_time  = vecs[i].tm;
            log_ready = vecs[i].log_ready;
            step;
            check($sformatf("miss[%0d].log_valid", i), 32'(log_valid), 32'(vecs[i].exp_lv));
            if (vecs[i].exp_lv)
                check($sformatf("miss[%0d].log_data", i), 32'(log_data), 32'(vecs[i].exp_ld));
            check($sformatf("miss[%0d].buzzer", i), 32'(buzzer), 32'(vecs[i].exp_buz));
            check($sformatf("miss[%0d].led", i), 32'(alert_led), 32'(vecs[i].exp_led));
            check($sformatf("miss[%0d].active_idx", i), 32'(active_idx), 32'(vecs[i].exp_aidx));
            check($sformatf("miss[%0d].pending", i), 32'(pending_cnt), 32'(vecs[i].exp_pend));
        end
        due_valid = 1'b0;

        // Taken: ack raised 5 cycles into ALERT reaches LOG on the 4th edge after
        tick = 1'b1;
        push(4'd5, 8'h10);
        step;
        check("taken_active_idx", 32'(active_idx), 32'd5);
        check("taken_led", 32'(alert_led), 32'd1);
        repeat (5) step;
        ack_btn = 1'b1;
        repeat (3) step;
        check("taken_pre_led", 32'(alert_led), 32'd1);
        step;
        check("taken_log_valid", 32'(log_valid), 32'd1);
        check("taken_log_data", 32'(log_data), 32'(rec(8'h10, 4'd5, 2'b00)));
        check("taken_buzzer", 32'(buzzer), 32'd0);
        check("taken_led_off", 32'(alert_led), 32'd0);
        step;
        check("taken_done", 32'(log_valid), 32'd0);
        ack_btn = 1'b0;

        // Ack pulse lands on the same edge as the final alert tick
        push(4'd6, 8'h20);
        step;
        check("simul_led", 32'(alert_led), 32'd1);
        repeat (12) step;
        ack_btn = 1'b1;
        repeat (3) step;
        check("simul_pre_led", 32'(alert_led), 32'd1);
        step;
        check("simul_log_valid", 32'(log_valid), 32'd1);
        check("simul_log_data", 32'(log_data), 32'(rec(8'h20, 4'd6, 2'b00)));
        step;
        ack_btn = 1'b0;

        // Snooze limit: two 32-cycle snoozes, third press ignored, then MISSED
        push(4'd7, 8'h33);
        step;
        check("snz_led", 32'(alert_led), 32'd1);
        for (int p = 0; p < 2; p++) begin
            snooze_btn = 1'b1;
            repeat (4) step;
            check($sformatf("snz%0d_enter_led", p), 32'(alert_led), 32'd0);
            check($sformatf("snz%0d_buzzer", p), 32'(buzzer), 32'd0);
            check($sformatf("snz%0d_active_idx", p), 32'(active_idx), 32'd7);
            snooze_btn = 1'b0;
            n = 0;
            while (alert_led !== 1'b1 && n < 100) begin
                step;
                n++;
            end
            check($sformatf("snz%0d_len", p), 32'(n), 32'd32);
        end
        snooze_btn = 1'b1;
        repeat (4) step;
        check("snz_third_ignored", 32'(alert_led), 32'd1);
        snooze_btn = 1'b0;
        n = 0;
        while (log_valid !== 1'b1 && n < 100) begin
            step;
            n++;
        end
        check("snz_final_alert_len", 32'(n), 32'd12);
        check("snz_log_data", 32'(log_data), 32'(rec(8'h33, 4'd7, 2'b01)));
        step;

        // Backlog: one active dose, five more due pulses, fifth dropped
        tick = 1'b0;
        push(4'd1, 8'h01);
        step;
        check("bl_active_idx", 32'(active_idx), 32'd1);
        for (int k = 2; k <= 6; k++) begin
            due_valid = 1'b1;
            due_idx   = 4'(k);
            due_time  = 8'(k);
            step;
            check($sformatf("bl_pending_%0d", k), 32'(pending_cnt), 32'((k - 1 > 4) ? 4 : k - 1));
            check($sformatf("bl_overflow_%0d", k), 32'(overflow), 32'(k == 6));
        end
        due_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            wait_alert(10);
            check($sformatf("bl_idx_%0d", k), 32'(active_idx), 32'(k));
            press_ack;
            wait_log(10);
            check($sformatf("bl_rec_%0d", k), 32'(log_data), 32'(rec(8'(k), 4'(k), 2'b00)));
            step;
        end
        check("bl_pending_end", 32'(pending_cnt), 32'd0);
        check("bl_overflow_sticky", 32'(overflow), 32'd1);

        // Log backpressure holds the record and blocks the next pop
        log_ready = 1'b0;
        push(4'd8, 8'h80);
        push(4'd9, 8'h90);
        wait_alert(10);
        check("bp_active_idx", 32'(active_idx), 32'd8);
        press_ack;
        wait_log(10);
        for (int c = 0; c < 10; c++) begin
            step;
            check($sformatf("bp_hold%0d_valid", c), 32'(log_valid), 32'd1);
            check($sformatf("bp_hold%0d_data", c), 32'(log_data), 32'(rec(8'h80, 4'd8, 2'b00)));
            check($sformatf("bp_hold%0d_pending", c), 32'(pending_cnt), 32'd1);
        end
        log_ready = 1'b1;
        step;
        check("bp_accept_valid", 32'(log_valid), 32'd0);
        check("bp_accept_idle_idx", 32'(active_idx), 32'd0);
        check("bp_accept_pending", 32'(pending_cnt), 32'd1);
        step;
        check("bp_next_led", 32'(alert_led), 32'd1);
        check("bp_next_idx", 32'(active_idx), 32'd9);
        check("bp_next_pending", 32'(pending_cnt), 32'd0);
        press_ack;
        wait_log(10);
        check("bp_next_rec", 32'(log_data), 32'(rec(8'h90, 4'd9, 2'b00)));
        step;

        // Reset while snoozing with one entry still pending
        tick = 1'b1;
        push(4'd10, 8'h5A);
        push(4'd11, 8'h5B);
        snooze_btn = 1'b1;
        repeat (4) step;
        check("rs_snooze_led", 32'(alert_led), 32'd0);
        check("rs_snooze_idx", 32'(active_idx), 32'd10);
        check("rs_snooze_pending", 32'(pending_cnt), 32'd1);
        snooze_btn = 1'b0;
        repeat (3) step;
        #2 rst_n = 1'b0;
        #1;
        check("rs_log_valid", 32'(log_valid), 32'd0);
        check("rs_log_data", 32'(log_data), 32'd0);
        check("rs_buzzer", 32'(buzzer), 32'd0);
        check("rs_led", 32'(alert_led), 32'd0);
        check("rs_active_idx", 32'(active_idx), 32'd0);
        check("rs_pending", 32'(pending_cnt), 32'd0);
        check("rs_overflow", 32'(overflow), 32'd0);
        #2 rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step;
            check($sformatf("rs_after%0d_valid", c), 32'(log_valid), 32'd0);
            check($sformatf("rs_after%0d_led", c), 32'(alert_led), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
